// File: rtl/seven_segment_pkg.sv
// Shared types for the seven-segment display arbiter: owner encodings,
// digit geometry and the registered display frame.
package seven_segment_pkg;

  localparam int NIB_W      = 4;
  localparam int NUM_DIGITS = 4;
  localparam int VAL_W      = NIB_W * NUM_DIGITS;

  // Owner encoding doubles as the one-hot gnt value.
  typedef enum logic [1:0] {
    GNT_IDLE = 2'b00,
    GNT_0    = 2'b01,
    GNT_1    = 2'b10
  } gnt_e;

  // One display frame as handed to the segment controller.
  typedef struct packed {
    logic [NUM_DIGITS-1:0][NIB_W-1:0] num;
    logic [NUM_DIGITS-1:0]            dots;
    logic [NUM_DIGITS-1:0]            en;
  } frame_t;

endpackage

// File: rtl/seven_segment_if.sv
// Requester/display bundle between the two requesters and the arbiter.
// master: the requester side; slave: the arbiter.
interface seven_segment_if;
  import seven_segment_pkg::*;

  logic [1:0]            req;
  logic [VAL_W-1:0]      val0;
  logic [VAL_W-1:0]      val1;
  logic [NUM_DIGITS-1:0] dots0;
  logic [NUM_DIGITS-1:0] dots1;
  logic [NUM_DIGITS-1:0] en0;
  logic [NUM_DIGITS-1:0] en1;

  logic [1:0]            gnt;
  logic [NIB_W-1:0]      num0, num1, num2, num3;
  logic                  dot0, dot1, dot2, dot3;
  logic [NUM_DIGITS-1:0] dgt_en;

  modport master (
    output req, val0, val1, dots0, dots1, en0, en1,
    input  gnt, num0, num1, num2, num3, dot0, dot1, dot2, dot3, dgt_en
  );

  modport slave (
    input  req, val0, val1, dots0, dots1, en0, en1,
    output gnt, num0, num1, num2, num3, dot0, dot1, dot2, dot3, dgt_en
  );

endinterface

// File: rtl/seven_segment_lz_mask.sv
// Leading-zero blanking mask: scanning from the top digit down, enables are
// cleared until the first nonzero digit. Digit 0 always stays enabled so a
// value of zero still shows a single "0".
module seven_segment_lz_mask
  import seven_segment_pkg::*;
(
  input  logic [VAL_W-1:0]      val,
  output logic [NUM_DIGITS-1:0] mask
);

  logic [NUM_DIGITS-1:0][NIB_W-1:0] dig;
  logic                             seen;

  assign dig = val;

  // Sticky "nonzero seen" from the top digit down.
  always_comb begin
    mask = '0;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      seen    = seen | (dig[i] != '0);
      mask[i] = seen;
    end
    mask[0] = 1'b1;
  end

endmodule

// File: rtl/seven_segment_arbiter.sv
// Two-requester arbiter for the shared 4-digit seven-segment display.
// Round-robin on contention, HOLD_CYCLES minimum ownership before
// pre-emption, registered owner frame, blank display when idle.
// Optional leading-zero blanking is built when DISP_LZ_BLANK_EN is defined.
module seven_segment_arbiter
  import seven_segment_pkg::*;
#(
  parameter int HOLD_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  seven_segment_if.slave bus
);

  localparam int            HC_W     = $clog2(HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(HOLD_CYCLES - 1);

  gnt_e            state, state_nxt;
  logic [HC_W-1:0] hold_cnt;
  logic            last_owner;
  frame_t          frame, frame_d;
  logic [NUM_DIGITS-1:0] en_mask;

  // Grant state, hold counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= GNT_IDLE;
      hold_cnt   <= '0;
      last_owner <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) hold_cnt <= '0;
      else if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
      if (state_nxt != state && state_nxt == GNT_0) last_owner <= 1'b0;
      if (state_nxt != state && state_nxt == GNT_1) last_owner <= 1'b1;
    end
  end

  // Next owner: direct handover on release, pre-emption once hold expires.
  always_comb begin
    state_nxt = state;
    case (state)
      GNT_IDLE: begin
        case (bus.req)
          2'b01:   state_nxt = GNT_0;
          2'b10:   state_nxt = GNT_1;
          2'b11:   state_nxt = last_owner ? GNT_0 : GNT_1;
          default: state_nxt = GNT_IDLE;
        endcase
      end
      GNT_0: begin
        if (!bus.req[0])                          state_nxt = bus.req[1] ? GNT_1 : GNT_IDLE;
        else if (bus.req[1] && hold_cnt == HOLD_MAX) state_nxt = GNT_1;
      end
      GNT_1: begin
        if (!bus.req[1])                          state_nxt = bus.req[0] ? GNT_0 : GNT_IDLE;
        else if (bus.req[0] && hold_cnt == HOLD_MAX) state_nxt = GNT_0;
      end
      default: state_nxt = GNT_IDLE;
    endcase
  end

`ifdef DISP_LZ_BLANK_EN
  logic [VAL_W-1:0] own_val;
  assign own_val = (state == GNT_1) ? bus.val1 : bus.val0;

  seven_segment_lz_mask u_lz_mask (
    .val  (own_val),
    .mask (en_mask)
  );
`else
  assign en_mask = '1;
`endif

  // Frame source follows the current owner, so the grant-changing edge
  // still captures the outgoing owner's data and frames never mix owners.
  always_comb begin
    frame_d = '0;
    case (state)
      GNT_0: begin
        frame_d.num  = bus.val0;
        frame_d.dots = bus.dots0;
        frame_d.en   = bus.en0 & en_mask;
      end
      GNT_1: begin
        frame_d.num  = bus.val1;
        frame_d.dots = bus.dots1;
        frame_d.en   = bus.en1 & en_mask;
      end
      default: frame_d = '0;
    endcase
  end

  // Registered display frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame <= '0;
    else        frame <= frame_d;
  end

  assign bus.gnt    = state;
  assign bus.num0   = frame.num[0];
  assign bus.num1   = frame.num[1];
  assign bus.num2   = frame.num[2];
  assign bus.num3   = frame.num[3];
  assign bus.dot0   = frame.dots[0];
  assign bus.dot1   = frame.dots[1];
  assign bus.dot2   = frame.dots[2];
  assign bus.dot3   = frame.dots[3];
  assign bus.dgt_en = frame.en;

  gnt_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) bus.gnt != 2'b11);

endmodule

// File: tb/tb_seven_segment_arbiter.sv
// Directed bench for seven_segment_arbiter with HOLD_CYCLES=4.
module tb_seven_segment_arbiter;
  import seven_segment_pkg::*;

`ifdef DISP_LZ_BLANK_EN
  localparam logic [3:0] LZ_0040 = 4'b0011;
  localparam logic [3:0] LZ_0000 = 4'b0001;
  localparam logic [3:0] LZ_0400 = 4'b0111;
`else
  localparam logic [3:0] LZ_0040 = 4'b1111;
  localparam logic [3:0] LZ_0000 = 4'b1111;
  localparam logic [3:0] LZ_0400 = 4'b1111;
`endif

  logic clk, rst_n;
  int   errs, nchk;

  seven_segment_if bus ();

  seven_segment_arbiter #(.HOLD_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [15:0] num,
                           input logic [3:0] dots, input logic [3:0] en);
    chk({tag, ".num"},  {bus.num3, bus.num2, bus.num1, bus.num0}, num);
    chk({tag, ".dots"}, {bus.dot3, bus.dot2, bus.dot1, bus.dot0}, dots);
    chk({tag, ".en"},   bus.dgt_en, en);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errs = 0; nchk = 0;
    rst_n = 1'b0;
    bus.req = 2'b00;
    bus.val0 = '0; bus.val1 = '0;
    bus.dots0 = '0; bus.dots1 = '0;
    bus.en0 = '0; bus.en1 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // idle after reset
    repeat (5) step();
    chk("idle.gnt", bus.gnt, 2'b00);
    chk_frame("idle", 16'h0000, 4'h0, 4'h0);

    // single owner, grant then data one edge later
    bus.val0 = 16'h1234; bus.dots0 = 4'b0101; bus.en0 = 4'b1111;
    bus.req = 2'b01;
    step();
    chk("own0.gnt", bus.gnt, 2'b01);
    chk("own0.early", {bus.num3, bus.num2, bus.num1, bus.num0}, 16'h0000);
    step();
    chk_frame("own0", 16'h1234, 4'b0101, 4'b1111);
    repeat (10) step();
    chk("own0.uncontested", bus.gnt, 2'b01);

    // release to idle: last data on dropping edge, blank after
    bus.req = 2'b00;
    step();
    chk("rel.gnt", bus.gnt, 2'b00);
    chk_frame("rel.last", 16'h1234, 4'b0101, 4'b1111);
    step();
    chk_frame("rel.blank", 16'h0000, 4'h0, 4'h0);

    // contention: owner keeps gnt exactly 4 cycles
    bus.req = 2'b01;
    step();
    chk("hold.c1", bus.gnt, 2'b01);
    bus.req = 2'b11;
    bus.val1 = 16'h5678; bus.dots1 = 4'b1010; bus.en1 = 4'b1111;
    step(); chk("hold.c2", bus.gnt, 2'b01);
    step(); chk("hold.c3", bus.gnt, 2'b01);
    step(); chk("hold.c4", bus.gnt, 2'b01);
    step();
    chk("preempt.gnt", bus.gnt, 2'b10);
    chk_frame("preempt.out", 16'h1234, 4'b0101, 4'b1111);
    step();
    chk("own1.gnt", bus.gnt, 2'b10);
    chk_frame("own1", 16'h5678, 4'b1010, 4'b1111);

    // owner 1 releases with req0 waiting: direct handover
    bus.req = 2'b01;
    step();
    chk("hand.gnt", bus.gnt, 2'b01);
    chk_frame("hand.out", 16'h5678, 4'b1010, 4'b1111);
    step();
    chk("hand.gnt2", bus.gnt, 2'b01);
    chk_frame("hand.new", 16'h1234, 4'b0101, 4'b1111);

    // asynchronous reset mid-ownership
    #3 rst_n = 1'b0;
    #1;
    chk("arst.gnt", bus.gnt, 2'b00);
    chk_frame("arst", 16'h0000, 4'h0, 4'h0);
    bus.req = 2'b00;
    #2 rst_n = 1'b1;
    step();
    chk("arst.idle", bus.gnt, 2'b00);

    // simultaneous request alternates on last owner
    bus.req = 2'b11;
    step();
    chk("rr.first", bus.gnt, 2'b01);
    bus.req = 2'b00;
    step();
    chk("rr.idle", bus.gnt, 2'b00);
    step();
    bus.req = 2'b11;
    step();
    chk("rr.second", bus.gnt, 2'b10);
    step();
    chk_frame("rr.own1", 16'h5678, 4'b1010, 4'b1111);
    bus.req = 2'b00;
    step(); step();

    // leading-zero blanking
    bus.val0 = 16'h0040; bus.dots0 = 4'b0000; bus.en0 = 4'b1111;
    bus.req = 2'b01;
    step(); step();
    chk_frame("lz.0040", 16'h0040, 4'b0000, LZ_0040);
    bus.val0 = 16'h0000;
    step();
    chk_frame("lz.0000", 16'h0000, 4'b0000, LZ_0000);
    bus.val0 = 16'h0400;
    step();
    chk("lz.0400", bus.dgt_en, LZ_0400);
    bus.val0 = 16'h1234; bus.en0 = 4'b1010;
    step();
    chk("lz.enmask", bus.dgt_en, 4'b1010);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
